// File: rtl/vram_arbiter.sv
// Frame-buffer RAM port arbiter: display fetch owns every visible cycle, and
// pixel-writer requests wait in a small FIFO that is drained during blanking.
module vram_arbiter #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [9:0]        CURRENT_PIXEL,
    input  logic [9:0]        CURRENT_LINE,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_READY,
    output logic              WR_DROP,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned FB_SIZE = H_VISIBLE * V_VISIBLE;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];

    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               wr_drop_q, wr_drop_d;
    logic               vis_d1_q, vis_d1_d;
    logic               pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0]  pix_data_q, pix_data_d;

    logic               visible_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               head_in_range_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [DATA_W-1:0]  head_data_s;
    logic [ADDR_W-1:0]  disp_addr_s;

    // Visibility, FIFO handshake and head-of-queue decode.
    always_comb begin
        visible_s       = (32'(CURRENT_PIXEL) < H_VISIBLE) && (32'(CURRENT_LINE) < V_VISIBLE);
        full_s          = (count_q == FULL_CNT);
        push_s          = WR_REQ && WR_READY;
        // Drain is armed one cycle behind the FIFO becoming non-empty, so a
        // stale DRAIN state with an empty FIFO must not pop.
        pop_s           = (state_q == ST_DRAIN) && !visible_s && (count_q != {CNT_W{1'b0}});
        head_addr_s     = fifo_addr_q[rd_ptr_q];
        head_data_s     = fifo_data_q[rd_ptr_q];
        head_in_range_s = (32'(head_addr_s) < FB_SIZE);
        disp_addr_s     = ADDR_W'(CURRENT_LINE) * ADDR_W'(H_VISIBLE) + ADDR_W'(CURRENT_PIXEL);
    end

    assign WR_READY = !full_s && !RESET;

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next state and registered RAM-port / pixel-pipeline values.
    always_comb begin
        state_d     = ST_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_drop_d   = 1'b0;
        vis_d1_d    = visible_s;
        pix_valid_d = vis_d1_q;
        pix_data_d  = vis_d1_q ? MEM_RDATA : {DATA_W{1'b0}};

        if (visible_s) begin
            state_d = ST_DISPLAY;
        end else if (count_q != {CNT_W{1'b0}}) begin
            state_d = ST_DRAIN;
        end else begin
            state_d = ST_IDLE;
        end

        if (visible_s) begin
            mem_addr_d = disp_addr_s;
        end else if (pop_s) begin
            if (head_in_range_s) begin
                mem_addr_d  = head_addr_s;
                mem_wdata_d = head_data_s;
                mem_we_d    = 1'b1;
            end else begin
                wr_drop_d   = 1'b1;
            end
        end else begin
            mem_we_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
            wr_drop_q   <= 1'b0;
            vis_d1_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_drop_q   <= wr_drop_d;
            vis_d1_q    <= vis_d1_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge CLOCK) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= WR_ADDR;
            fifo_data_q[wr_ptr_q] <= WR_DATA;
        end
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WE    = mem_we_q;
    assign WR_DROP   = wr_drop_q;
    assign PIX_DATA  = pix_data_q;
    assign PIX_VALID = pix_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter against a queue-based model.
module tb_vram_arbiter;

    logic        CLOCK;
    logic        RESET;
    logic [9:0]  CURRENT_PIXEL;
    logic [9:0]  CURRENT_LINE;
    logic        WR_REQ;
    logic [18:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic        WR_READY;
    logic        WR_DROP;
    logic [18:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_WE;
    logic [7:0]  MEM_RDATA;
    logic [7:0]  PIX_DATA;
    logic        PIX_VALID;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t        q[$];
    logic [18:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_we;
    logic        m_drop;
    logic        m_vis1;
    logic        m_pv;
    logic [7:0]  m_pd;
    logic        m_arm;

    vram_arbiter dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .CURRENT_PIXEL(CURRENT_PIXEL), .CURRENT_LINE(CURRENT_LINE),
        .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_READY(WR_READY), .WR_DROP(WR_DROP),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
        .MEM_RDATA(MEM_RDATA), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID)
    );

    function automatic logic [7:0] rd_fn(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign MEM_RDATA = rd_fn(MEM_ADDR);

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: check ready, advance the model from current inputs, check registered outputs.
    task automatic step();
        int   sz0;
        logic vis;
        logic rdy;
        ent_t e;
        #1;
        sz0 = q.size();
        chk("wr_ready", WR_READY, (sz0 < 4) && !RESET);
        vis = (CURRENT_PIXEL < 640) && (CURRENT_LINE < 480);
        if (RESET) begin
            q.delete();
            m_addr = 19'd0; m_wdata = 8'd0; m_we = 1'b0; m_drop = 1'b0;
            m_vis1 = 1'b0; m_pv = 1'b0; m_pd = 8'd0; m_arm = 1'b0;
        end else begin
            m_pd   = m_vis1 ? rd_fn(m_addr) : 8'h00;
            m_pv   = m_vis1;
            m_vis1 = vis;
            m_we   = 1'b0;
            m_drop = 1'b0;
            rdy    = (sz0 < 4);
            if (vis) begin
                m_addr = 19'(CURRENT_LINE * 640 + CURRENT_PIXEL);
            end else if (m_arm && sz0 > 0) begin
                e = q.pop_front();
                if (e.a < 307200) begin
                    m_addr = e.a; m_wdata = e.d; m_we = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end
            if (WR_REQ && rdy) begin
                e.a = WR_ADDR; e.d = WR_DATA;
                q.push_back(e);
            end
            m_arm = !vis && (sz0 > 0);
        end
        @(posedge CLOCK);
        #1;
        chk("mem_addr",  MEM_ADDR,  m_addr);
        chk("mem_wdata", MEM_WDATA, m_wdata);
        chk("mem_we",    MEM_WE,    m_we);
        chk("wr_drop",   WR_DROP,   m_drop);
        chk("pix_valid", PIX_VALID, m_pv);
        chk("pix_data",  PIX_DATA,  m_pd);
    endtask

    initial begin
        int pix;
        RESET = 1'b1; CURRENT_PIXEL = 10'd700; CURRENT_LINE = 10'd0;
        WR_REQ = 1'b0; WR_ADDR = 19'd0; WR_DATA = 8'd0;
        m_addr = 19'd0; m_wdata = 8'd0; m_we = 1'b0; m_drop = 1'b0;
        m_vis1 = 1'b0; m_pv = 1'b0; m_pd = 8'd0; m_arm = 1'b0;
        @(negedge CLOCK);
        step(); step();
        chk("rst_we", MEM_WE, 1'b0);
        chk("rst_addr", MEM_ADDR, 19'd0);
        chk("rst_pix_valid", PIX_VALID, 1'b0);
        RESET = 1'b0;

        // Display addressing and read pipeline
        CURRENT_LINE = 10'd2; CURRENT_PIXEL = 10'd5;
        step();
        chk("disp_addr_1285", MEM_ADDR, 19'd1285);
        CURRENT_PIXEL = 10'd700;
        step();
        chk("disp_pix_a5", PIX_DATA, 8'hA5);
        chk("disp_pix_valid", PIX_VALID, 1'b1);

        // Writes buffered during visible, drained in order at blanking
        CURRENT_LINE = 10'd0; CURRENT_PIXEL = 10'd100;
        for (int k = 0; k < 4; k++) begin
            WR_REQ = 1'b1; WR_ADDR = 19'(10 + k); WR_DATA = 8'(1 + k);
            step();
            CURRENT_PIXEL = CURRENT_PIXEL + 10'd1;
        end
        WR_REQ = 1'b0;
        chk("buf_full_ready", WR_READY, 1'b0);
        step(); step();
        chk("buf_visible_we", MEM_WE, 1'b0);
        CURRENT_PIXEL = 10'd640;
        step();
        chk("buf_arm_we", MEM_WE, 1'b0);
        for (int k = 0; k < 4; k++) begin
            CURRENT_PIXEL = CURRENT_PIXEL + 10'd1;
            step();
            chk("buf_drain_we", MEM_WE, 1'b1);
            chk("buf_drain_addr", MEM_ADDR, 19'(10 + k));
            chk("buf_drain_data", MEM_WDATA, 8'(1 + k));
        end

        // Blanking-to-visible boundary on line 5
        CURRENT_LINE = 10'd5; CURRENT_PIXEL = 10'd600;
        for (int k = 0; k < 4; k++) begin
            WR_REQ = 1'b1; WR_ADDR = 19'(3000 + k); WR_DATA = 8'(16 + k);
            step();
        end
        WR_REQ = 1'b0;
        CURRENT_PIXEL = 10'd798; step();
        chk("bnd_798_we", MEM_WE, 1'b0);
        CURRENT_PIXEL = 10'd799; step();
        chk("bnd_799_addr", MEM_ADDR, 19'd3000);
        CURRENT_PIXEL = 10'd800; step();
        chk("bnd_800_addr", MEM_ADDR, 19'd3001);
        CURRENT_PIXEL = 10'd0; step();
        chk("bnd_0_we", MEM_WE, 1'b0);
        chk("bnd_0_addr", MEM_ADDR, 19'd3200);
        CURRENT_PIXEL = 10'd640;
        for (int k = 0; k < 6; k++) begin
            step();
            CURRENT_PIXEL = CURRENT_PIXEL + 10'd1;
        end

        // Out-of-range write is dropped two cycles after the push
        CURRENT_LINE = 10'd490; CURRENT_PIXEL = 10'd10;
        WR_REQ = 1'b1; WR_ADDR = 19'd307200; WR_DATA = 8'h77;
        step();
        WR_REQ = 1'b0;
        step();
        chk("oor_drop_t1", WR_DROP, 1'b0);
        step();
        chk("oor_drop_t2", WR_DROP, 1'b1);
        chk("oor_we_t2", MEM_WE, 1'b0);
        step();
        chk("oor_drop_t3", WR_DROP, 1'b0);

        // Continuous requests: push and pop share cycles at count 2
        for (int k = 0; k < 8; k++) begin
            WR_REQ = 1'b1; WR_ADDR = 19'(100 + k); WR_DATA = 8'(k);
            step();
            if (k >= 2) begin
                chk("pp_we", MEM_WE, 1'b1);
                chk("pp_addr", MEM_ADDR, 19'(100 + k - 2));
                chk("pp_ready", WR_READY, 1'b1);
            end
        end
        WR_REQ = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Reset in the middle of a drain discards buffered entries
        CURRENT_LINE = 10'd0; CURRENT_PIXEL = 10'd100;
        for (int k = 0; k < 3; k++) begin
            WR_REQ = 1'b1; WR_ADDR = 19'(200 + k); WR_DATA = 8'(k + 40);
            step();
        end
        WR_REQ = 1'b0;
        CURRENT_PIXEL = 10'd640; step();
        RESET = 1'b1; CURRENT_PIXEL = 10'd641; step();
        RESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            CURRENT_PIXEL = CURRENT_PIXEL + 10'd1;
            step();
            chk("rstd_we", MEM_WE, 1'b0);
            chk("rstd_ready", WR_READY, 1'b1);
        end

        // Randomized scan segments
        for (int s = 0; s < 60; s++) begin
            CURRENT_LINE = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(480, 524))
                                                        : 10'($urandom_range(0, 479));
            pix = $urandom_range(0, 799);
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 19) == 0) pix = $urandom_range(0, 799);
                CURRENT_PIXEL = 10'(pix);
                pix = (pix + 1) % 800;
                RESET   = ($urandom_range(0, 59) == 0);
                WR_REQ  = $urandom_range(0, 1) == 1;
                WR_ADDR = ($urandom_range(0, 7) == 0) ? 19'(307200 + $urandom_range(0, 999))
                                                      : 19'($urandom_range(0, 307199));
                WR_DATA = 8'($urandom);
                step();
            end
        end
        RESET = 1'b0; WR_REQ = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Owns the single port of the frame-buffer RAM and shares it between display fetch and a pixel-writer client. The display side gets every cycle of the visible area, using CURRENT_PIXEL and CURRENT_LINE from the horizontal and vertical counters. Writer requests are buffered in a small FIFO and drained only during horizontal or vertical blanking. It sits between the H/V counters, the frame-buffer RAM and the drawing logic in Graphic_controller.

## Interface
- H_VISIBLE, 640: visible pixels per line.
- V_VISIBLE, 480: visible lines per frame.
- ADDR_W, 19: RAM address width; must satisfy 2^ADDR_W ≥ H_VISIBLE*V_VISIBLE.
- DATA_W, 8: pixel width.
- FIFO_DEPTH, 4: write-buffer entries (power of two, ≥2).
- CLOCK  in  1: pixel clock, rising edge.
- RESET  in  1: synchronous, active-high.
- CURRENT_PIXEL  in  10: horizontal position from the H counter.
- CURRENT_LINE  in  10: vertical position from the V counter.
- WR_REQ  in  1: writer presents a pixel write.
- WR_ADDR  in  ADDR_W: linear pixel address, line*H_VISIBLE+pixel.
- WR_DATA  in  DATA_W: pixel value.
- WR_READY  out  1: FIFO can accept; a push occurs when WR_REQ and WR_READY are both high on an edge.
- WR_DROP  out  1: 1-cycle pulse when a popped entry is discarded as out of range.
- MEM_ADDR  out  ADDR_W: registered RAM address.
- MEM_WDATA  out  DATA_W: registered RAM write data.
- MEM_WE  out  1: registered RAM write enable.
- MEM_RDATA  in  DATA_W: RAM read data, valid 1 cycle after MEM_ADDR.
- PIX_DATA  out  DATA_W: pixel to the DAC.
- PIX_VALID  out  1: PIX_DATA corresponds to a visible pixel.

## Operation
- VISIBLE = (CURRENT_PIXEL < H_VISIBLE) && (CURRENT_LINE < V_VISIBLE), evaluated each cycle from the inputs.
- State machine with 3 states, registered:
  - IDLE: blanking with FIFO empty.
  - DRAIN: blanking with FIFO non-empty.
  - DISPLAY: VISIBLE is high.
- Transitions, evaluated every cycle in priority order:
  - VISIBLE → DISPLAY.
  - else FIFO non-empty → DRAIN.
  - else IDLE.
- DISPLAY:
  - MEM_ADDR ← CURRENT_LINE*H_VISIBLE + CURRENT_PIXEL, computed at ADDR_W width, no truncation for legal parameters.
  - MEM_WE ← 0.
  - The FIFO is never popped.
- DRAIN:
  - Pop the head entry, one per cycle.
  - If WR_ADDR < H_VISIBLE*V_VISIBLE: MEM_ADDR ← addr, MEM_WDATA ← data, MEM_WE ← 1.
  - Otherwise: MEM_WE ← 0 and WR_DROP ← 1 for that cycle.
- IDLE: MEM_WE ← 0; MEM_ADDR and MEM_WDATA hold.
- FIFO behaviour:
  - Circular buffer with read and write pointers plus a count.
  - WR_READY = !full && !RESET.
  - A push and a pop in the same cycle is legal when not full; count is unchanged.
  - At full, WR_READY is low even if a pop happens that cycle; no combinational ready-through.
- Display pipeline:
  - PIX_VALID is VISIBLE delayed by 2 cycles.
  - PIX_DATA ← MEM_RDATA registered when the delayed-by-1 VISIBLE is high, else 0.
- Write requests arriving during DISPLAY are buffered until the next blanking cycle, and they retain order.

## Timing
- Reset values:
  - MEM_ADDR=0, MEM_WDATA=0, MEM_WE=0.
  - PIX_DATA=0, PIX_VALID=0, WR_DROP=0.
  - FIFO empty, state IDLE.
  - RESET aborts any drain; buffered entries are discarded and not written.
- Display latency: pixel (p,l) sampled at cycle t → MEM_ADDR at t+1 → PIX_DATA/PIX_VALID at t+2.
- Write latency in blanking with the FIFO empty: push at edge t → MEM_WE high at t+2.
- Visible-start boundary: if VISIBLE rises at cycle t, the MEM_WE registered at t is 0. A write issued at t-1 completes at t, and there is no port conflict.
- Wrap-around: pointers wrap modulo FIFO_DEPTH. Count saturates only via the WR_READY gating and never exceeds FIFO_DEPTH.
- Drain bandwidth: one write per blanking cycle, so 160 writes per line for an 800-clock line.

## Test plan
- Reset mid-drain: FIFO holds 3 entries and RESET is asserted for 1 cycle during blanking → following cycles have MEM_WE=0, WR_READY=1, and none of the 3 entries is ever written.
- Display addressing: CURRENT_LINE=2, CURRENT_PIXEL=5, RESET low → MEM_ADDR=1285 one cycle later. With MEM_RDATA=8'hA5 → PIX_DATA=8'hA5 and PIX_VALID=1 two cycles later.
- Buffered during visible: 4 pushes (addr 10..13, data 1..4) at CURRENT_PIXEL=100, line 0 → WR_READY=0 after the 4th push and MEM_WE stays 0. Starting at CURRENT_PIXEL=640 → 4 consecutive MEM_WE pulses at addresses 10, 11, 12, 13 in order.
- Boundary: entries pending with CURRENT_PIXEL stepping 798, 799, 800, 0 on line 5 → writes at the blanking cycles only, and MEM_WE=0 from the cycle after CURRENT_PIXEL=0 is sampled.
- Out of range: push WR_ADDR=307200 during blanking → MEM_WE stays 0 and WR_DROP pulses once, 2 cycles after the push.
- Simultaneous push/pop: count=2 in blanking with WR_REQ held high → count stays 2, WR_READY stays 1, and one write is issued per cycle.
